wb_rr_arb: RTL and testbench

- Round-robin Wishbone B4 (classic) arbiter.
- Shares the single user-project Wishbone slave port between NUM_M masters: the external wb_host bridge, the RISC-V core data port and the debug/DMA master.
- Grant is held for the whole CYC envelope, so bursts and read-modify-write sequences are atomic.
- A per-transfer watchdog returns ERR to the owning master when a slave never acknowledges. This prevents a hung peripheral from locking the bus and stalling firmware status reporting on the GPIO checkbits.

---
 rtl/wb_rr_arb_pkg.sv | 31 +++
 rtl/wb_rr_pick.sv | 37 +++
 rtl/wb_rr_arb.sv | 155 +++++++++++++++
 tb/tb_wb_rr_arb.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_rr_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter and its picker.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package wb_arb_pkg;

  // Arbiter control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TOUT = 2'd2
  } arb_state_e;

  // Default widths and limits
  localparam int DEF_NUM_M    = 3;
  localparam int DEF_AW       = 32;
  localparam int DEF_DW       = 32;
  localparam int DEF_TOUT_CYC = 256;
  localparam int MAX_M        = 8;
  localparam int MAX_IW       = 3;

  // Binary index of the set bit in a one-hot vector (zero when empty)
  function automatic logic [MAX_IW-1:0] onehot2idx(input logic [MAX_M-1:0] oh);
    logic [MAX_IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_M; i++) begin
      if (oh[i]) idx = idx | MAX_IW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Rotating-priority picker: first requester strictly after 'last', wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int NUM_M = DEF_NUM_M,
  parameter int IW    = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [NUM_M-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             vld
);

  int  cand;
  logic found;

  // Scan upward from last+1 modulo NUM_M, taking the first active request
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 1; off <= NUM_M; off++) begin
      cand = int'(last) + off;
      if (cand >= NUM_M) cand = cand - NUM_M;
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        found     = 1'b1;
      end
    end
    vld = found;
    idx = IW'(onehot2idx(MAX_M'(gnt)));
  end

endmodule

// File: rtl/wb_rr_arb.sv
// Round-robin Wishbone B4 classic arbiter: grant held for the whole CYC, watchdog ERR on hung slaves.
// Latency: 1 cycle from m_cyc_i to s_cyc_o; data path is a combinational mux from the registered grant.
// Backpressure: losers wait (no preemption); a stalled transfer is terminated with ERR after TOUT_CYC cycles.
module wb_rr_arb
  import wb_arb_pkg::*;
#(
  parameter int NUM_M    = DEF_NUM_M,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int TOUT_CYC = DEF_TOUT_CYC
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic [NUM_M-1:0]      m_cyc_i,
  input  logic [NUM_M-1:0]      m_stb_i,
  input  logic [NUM_M-1:0]      m_we_i,
  input  logic [NUM_M*AW-1:0]   m_adr_i,
  input  logic [NUM_M*DW-1:0]   m_dat_i,
  input  logic [NUM_M*DW/8-1:0] m_sel_i,
  output logic [DW-1:0]         m_dat_o,
  output logic [NUM_M-1:0]      m_ack_o,
  output logic [NUM_M-1:0]      m_err_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [AW-1:0]         s_adr_o,
  output logic [DW-1:0]         s_dat_o,
  output logic [DW/8-1:0]       s_sel_o,
  input  logic [DW-1:0]         s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  output logic [NUM_M-1:0]      gnt_o,
  output logic                  tout_o
);

  localparam int SW = DW / 8;
  localparam int IW = $clog2(NUM_M);
  localparam int TW = $clog2(TOUT_CYC);
  localparam logic [TW-1:0] TMAX = TW'(TOUT_CYC - 1);

  arb_state_e       state_q;
  logic [IW-1:0]    gidx_q;
  logic [IW-1:0]    last_q;
  logic [TW-1:0]    timer_q;
  logic             tout_q;

  logic [NUM_M-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_vld;

  logic             busy;
  logic             cyc_g;
  logic             stall;
  logic             expire;

  wb_rr_pick #(
    .NUM_M (NUM_M),
    .IW    (IW)
  ) u_pick (
    .req  (m_cyc_i),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .vld  (pick_vld)
  );

  assign busy    = (state_q == BUSY);
  assign cyc_g   = m_cyc_i[gidx_q];
  assign stall   = s_stb_o & ~s_ack_i & ~s_err_i;
  // A slave response in the expiry cycle wins over the watchdog
  assign expire  = stall && (timer_q == TMAX);
  assign m_dat_o = s_dat_i;
  assign tout_o  = tout_q;

  // Route the granted master to the slave only while a transfer is live
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (busy) begin
      s_cyc_o = cyc_g;
      s_stb_o = m_stb_i[gidx_q];
      s_we_o  = m_we_i[gidx_q];
      s_adr_o = m_adr_i[int'(gidx_q)*AW +: AW];
      s_dat_o = m_dat_i[int'(gidx_q)*DW +: DW];
      s_sel_o = m_sel_i[int'(gidx_q)*SW +: SW];
    end
  end

  // Steer slave responses (or the watchdog ERR) back to the owner only
  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    if (busy) begin
      m_ack_o[gidx_q] = s_ack_i;
      m_err_o[gidx_q] = s_err_i | expire;
    end
  end

  // Arbitration FSM with grant ownership, rotation pointer and watchdog timer
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_o   <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_M - 1);
      timer_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      tout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q <= BUSY;
            gnt_o   <= pick_gnt;
            gidx_q  <= pick_idx;
            last_q  <= pick_idx;
            timer_q <= '0;
          end
        end
        BUSY: begin
          if (!cyc_g) begin
            state_q <= IDLE;
            gnt_o   <= '0;
            timer_q <= '0;
          end else if (expire) begin
            // Timer stays at TMAX so it never wraps
            state_q <= TOUT;
            tout_q  <= 1'b1;
          end else if (stall) begin
            timer_q <= timer_q + TW'(1);
          end else begin
            timer_q <= '0;
          end
        end
        TOUT: begin
          if (!cyc_g) begin
            state_q <= IDLE;
            gnt_o   <= '0;
            timer_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_o   <= '0;
          timer_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arb.sv
// Bench for wb_rr_arb: directed scenarios plus random traffic against a transaction-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_rr_arb;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic              clk_i = 1'b0;
  logic              rst_n;
  logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
  logic [NM*AW-1:0]  m_adr_i;
  logic [NM*DW-1:0]  m_dat_i;
  logic [NM*SW-1:0]  m_sel_i;
  logic [DW-1:0]     m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [SW-1:0]     s_sel_o;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack_i, s_err_i;
  logic [NM-1:0]     gnt_o;
  logic              tout_o;

  always #5 clk_i = ~clk_i;

  wb_rr_arb #(.NUM_M(NM), .AW(AW), .DW(DW), .TOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .gnt_o(gnt_o), .tout_o(tout_o)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the bus, whom it rotates from, how long the owner has stalled
  int owner;       // -1 when nobody holds the bus
  int last;
  int wait_cnt;
  bit in_tout;
  bit tout_pend;
  int dut_touts = 0;
  int exp_touts = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1; last = NM - 1; wait_cnt = 0; in_tout = 1'b0; tout_pend = 1'b0;
  endtask

  function automatic bit expire_now();
    return (owner >= 0) && !in_tout && m_stb_i[owner] && !s_ack_i && !s_err_i
           && (wait_cnt == TO - 1);
  endfunction

  task automatic model_step();
    bit ex;
    ex = expire_now();
    tout_pend = ex;
    if (owner < 0) begin
      for (int k = 1; k <= NM; k++) begin
        if (owner < 0 && m_cyc_i[(last + k) % NM]) owner = (last + k) % NM;
      end
      if (owner >= 0) begin last = owner; wait_cnt = 0; end
    end else if (!m_cyc_i[owner]) begin
      owner = -1; in_tout = 1'b0; wait_cnt = 0;
    end else if (!in_tout) begin
      if (ex) in_tout = 1'b1;
      else if (m_stb_i[owner] && !s_ack_i && !s_err_i) wait_cnt++;
      else wait_cnt = 0;
    end
  endtask

  task automatic check_outputs();
    logic [NM-1:0] eg, ea, ee;
    logic ec, es, ew;
    logic [AW-1:0] eadr;
    logic [DW-1:0] ed;
    logic [SW-1:0] esel;
    bit live;
    eg = '0; ea = '0; ee = '0; ec = 1'b0; es = 1'b0; ew = 1'b0;
    eadr = '0; ed = '0; esel = '0;
    live = (owner >= 0) && !in_tout;
    if (owner >= 0) eg[owner] = 1'b1;
    if (live) begin
      ec   = m_cyc_i[owner];
      es   = m_stb_i[owner];
      ew   = m_we_i[owner];
      eadr = m_adr_i[owner*AW +: AW];
      ed   = m_dat_i[owner*DW +: DW];
      esel = m_sel_i[owner*SW +: SW];
      ea[owner] = s_ack_i;
      ee[owner] = s_err_i | expire_now();
    end
    if (tout_o === 1'b1) dut_touts++;
    if (tout_pend) exp_touts++;
    chk("gnt", gnt_o, eg);
    chk("s_cyc", s_cyc_o, ec);
    chk("s_stb", s_stb_o, es);
    chk("s_we", s_we_o, ew);
    chk("s_adr", s_adr_o, eadr);
    chk("s_dat", s_dat_o, ed);
    chk("s_sel", s_sel_o, esel);
    chk("m_ack", m_ack_o, ea);
    chk("m_err", m_err_o, ee);
    chk("tout", tout_o, tout_pend);
    chk("m_dat", m_dat_o, s_dat_i);
  endtask

  // Drive one cycle of stimulus just after the edge, check mid-cycle, advance the model on the edge
  task automatic tick(input logic [NM-1:0] c, input logic [NM-1:0] s, input logic a, input logic e);
    m_cyc_i = c;
    m_stb_i = s;
    m_we_i  = NM'($urandom);
    for (int k = 0; k < NM; k++) begin
      m_adr_i[k*AW +: AW] = $urandom;
      m_dat_i[k*DW +: DW] = $urandom;
      m_sel_i[k*SW +: SW] = SW'($urandom);
    end
    s_dat_i = $urandom;
    s_ack_i = a;
    s_err_i = e;
    @(negedge clk_i);
    check_outputs();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  initial begin
    logic [NM-1:0] rc, rs;
    logic ra, re;
    bit stall_ph;

    rst_n = 1'b0;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
    model_reset();
    #2;
    check_outputs();
    @(negedge clk_i);
    rst_n = 1'b1;
    @(posedge clk_i);
    model_step();
    #1;

    // Contention: all three request together; order m0, m1, m2, m0 with a dead cycle between
    tick(3'b111, 3'b111, 1'b0, 1'b0);
    chk("first_gnt_m0", gnt_o, 3'b001);
    tick(3'b111, 3'b111, 1'b1, 1'b0);
    tick(3'b110, 3'b110, 1'b0, 1'b0);
    tick(3'b110, 3'b110, 1'b0, 1'b0);
    chk("second_gnt_m1", gnt_o, 3'b010);
    tick(3'b110, 3'b110, 1'b1, 1'b0);
    tick(3'b100, 3'b100, 1'b0, 1'b0);
    tick(3'b100, 3'b100, 1'b0, 1'b0);
    chk("third_gnt_m2", gnt_o, 3'b100);
    tick(3'b100, 3'b100, 1'b1, 1'b0);
    tick(3'b011, 3'b011, 1'b0, 1'b0);
    tick(3'b011, 3'b011, 1'b0, 1'b0);
    chk("wrap_gnt_m0", gnt_o, 3'b001);
    tick(3'b000, 3'b000, 1'b0, 1'b0);
    tick(3'b000, 3'b000, 1'b0, 1'b0);

    // Single master m1 write
    tick(3'b010, 3'b010, 1'b0, 1'b0);
    chk("single_scyc", s_cyc_o, 1'b1);
    tick(3'b010, 3'b010, 1'b0, 1'b0);
    tick(3'b010, 3'b010, 1'b1, 1'b0);
    tick(3'b000, 3'b000, 1'b0, 1'b0);
    tick(3'b000, 3'b000, 1'b0, 1'b0);

    // Burst lock: m2 holds CYC for four beats while m0 waits
    tick(3'b100, 3'b100, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++) tick(3'b101, 3'b101, 1'b1, 1'b0);
    chk("burst_locked", gnt_o, 3'b100);
    tick(3'b001, 3'b001, 1'b0, 1'b0);
    tick(3'b001, 3'b001, 1'b0, 1'b0);
    chk("burst_next_m0", gnt_o, 3'b001);
    tick(3'b000, 3'b000, 1'b0, 1'b0);
    tick(3'b000, 3'b000, 1'b0, 1'b0);

    // Timeout: m1 strobes, slave silent, late ACK must be dropped
    tick(3'b010, 3'b010, 1'b0, 1'b0);
    for (int i = 0; i < TO; i++) tick(3'b010, 3'b010, 1'b0, 1'b0);
    chk("tout_pulse", tout_o, 1'b1);
    tick(3'b010, 3'b010, 1'b1, 1'b0);
    tick(3'b010, 3'b010, 1'b0, 1'b0);
    tick(3'b000, 3'b000, 1'b0, 1'b0);
    tick(3'b000, 3'b000, 1'b0, 1'b0);

    // Collision: ACK in the expiry cycle completes normally
    tick(3'b010, 3'b010, 1'b0, 1'b0);
    for (int i = 0; i < TO - 1; i++) tick(3'b010, 3'b010, 1'b0, 1'b0);
    tick(3'b010, 3'b010, 1'b1, 1'b0);
    chk("collision_no_tout", tout_o, 1'b0);
    chk("collision_still_gnt", gnt_o, 3'b010);
    tick(3'b000, 3'b000, 1'b0, 1'b0);
    tick(3'b000, 3'b000, 1'b0, 1'b0);

    // Reset during an m1 read
    tick(3'b010, 3'b010, 1'b0, 1'b0);
    tick(3'b010, 3'b010, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    m_cyc_i = 3'b011;
    m_stb_i = 3'b011;
    @(negedge clk_i);
    rst_n = 1'b1;
    #1;
    check_outputs();
    @(posedge clk_i);
    model_step();
    #1;
    chk("post_reset_m0", gnt_o, 3'b001);
    tick(3'b000, 3'b000, 1'b0, 1'b0);
    tick(3'b000, 3'b000, 1'b0, 1'b0);

    // Random traffic, with periodic phases where the slave stalls to provoke timeouts
    rc = '0;
    for (int blk = 0; blk < 40; blk++) begin
      stall_ph = (blk % 4 == 3);
      repeat (60) begin
        for (int k = 0; k < NM; k++) begin
          if ($urandom_range(0, stall_ph ? 40 : 6) == 0) rc[k] = ~rc[k];
          rs[k] = rc[k] & (stall_ph ? 1'b1 : ($urandom_range(0, 3) != 0));
        end
        ra = !stall_ph && ($urandom_range(0, 2) == 0);
        re = !stall_ph && ($urandom_range(0, 19) == 0);
        tick(rc, rs, ra, re);
      end
    end
    tick(3'b000, 3'b000, 1'b0, 1'b0);
    tick(3'b000, 3'b000, 1'b0, 1'b0);
    chk("tout_count", 64'(dut_touts), 64'(exp_touts));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
